// File: rtl/light_seq_param.sv
// Parametrised LED show sequencer: ALL -> RUN -> ALT -> GAP, stepped by a two-rate divider.
// Optional LIGHT_CYCLE_CNT_EN adds an 8-bit count of completed shows (cycle_cnt).
module light_seq_param #(
    parameter int WIDTH    = 8,
    parameter int SLOW_DIV = 50000,
    parameter int FAST_DIV = 5000,
    parameter int ALT_REPS = 1
) (
    input  logic             clk100khz,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       speed_mode,
    input  logic             dir,
    output logic [WIDTH-1:0] light,
    output logic [1:0]       phase,
    output logic             speed_fast,
    output logic             step_tick
`ifdef LIGHT_CYCLE_CNT_EN
    ,
    output logic [7:0]       cycle_cnt
`endif
);

    localparam int CW  = $clog2(SLOW_DIV);
    localparam int RCW = $clog2(WIDTH + 1);
    localparam int ACW = $clog2(2 * ALT_REPS + 1);

    localparam logic [CW-1:0]  SLOW_LAST = CW'(SLOW_DIV - 1);
    localparam logic [CW-1:0]  FAST_LAST = CW'(FAST_DIV - 1);
    localparam logic [RCW-1:0] RUN_LAST  = RCW'(WIDTH);
    localparam logic [ACW-1:0] ALT_LAST  = ACW'(2 * ALT_REPS);

    typedef enum logic [1:0] {
        PH_ALL = 2'd0,
        PH_RUN = 2'd1,
        PH_ALT = 2'd2,
        PH_GAP = 2'd3
    } phase_t;

    phase_t           phase_q, phase_d;
    logic [WIDTH-1:0] light_q, light_d;
    logic             fast_q, fast_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RCW-1:0]   run_q, run_d;
    logic [ACW-1:0]   alt_q, alt_d;
    logic             rdir_q, rdir_d;
    logic             tick_q, tick_d;
    logic [CW-1:0]    cnt_last;
    logic [WIDTH-1:0] pat_a;
`ifdef LIGHT_CYCLE_CNT_EN
    logic [7:0]       cyc_q, cyc_d;
`endif

    // Checkerboard with the MSB set: bit i lit when (WIDTH-1-i) is even.
    always_comb begin
        pat_a = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pat_a[i] = ((WIDTH - 1 - i) % 2) == 0;
        end
    end

    always_ff @(posedge clk100khz or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_GAP;
            light_q <= '0;
            fast_q  <= 1'b0;
            cnt_q   <= '0;
            run_q   <= '0;
            alt_q   <= '0;
            rdir_q  <= 1'b0;
            tick_q  <= 1'b0;
`ifdef LIGHT_CYCLE_CNT_EN
            cyc_q   <= '0;
`endif
        end else begin
            phase_q <= phase_d;
            light_q <= light_d;
            fast_q  <= fast_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            alt_q   <= alt_d;
            rdir_q  <= rdir_d;
            tick_q  <= tick_d;
`ifdef LIGHT_CYCLE_CNT_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    always_comb begin
        phase_d  = phase_q;
        light_d  = light_q;
        fast_d   = fast_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        alt_d    = alt_q;
        rdir_d   = rdir_q;
        tick_d   = 1'b0;
`ifdef LIGHT_CYCLE_CNT_EN
        cyc_d    = cyc_q;
`endif
        cnt_last = fast_q ? FAST_LAST : SLOW_LAST;

        if (en) begin
            if (cnt_q == cnt_last) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (phase_q)
                    PH_GAP: begin
                        phase_d = PH_ALL;
                        light_d = '1;
                    end
                    PH_ALL: begin
                        // Direction is latched here and held for the whole run.
                        phase_d = PH_RUN;
                        rdir_d  = dir;
                        light_d = dir ? WIDTH'(1) : {1'b1, {(WIDTH-1){1'b0}}};
                        run_d   = RCW'(1);
                    end
                    PH_RUN: begin
                        if (run_q == RUN_LAST) begin
                            phase_d = PH_ALT;
                            light_d = rdir_q ? ~pat_a : pat_a;
                            alt_d   = ACW'(1);
                        end else begin
                            light_d = rdir_q ? {light_q[WIDTH-2:0], 1'b0}
                                             : {1'b0, light_q[WIDTH-1:1]};
                            run_d   = run_q + RCW'(1);
                        end
                    end
                    PH_ALT: begin
                        if (alt_q == ALT_LAST) begin
                            // Rate change lands here so the GAP step already uses it.
                            phase_d = PH_GAP;
                            light_d = '0;
                            run_d   = '0;
                            alt_d   = '0;
                            case (speed_mode)
                                2'b00:   fast_d = ~fast_q;
                                2'b01:   fast_d = 1'b0;
                                2'b10:   fast_d = 1'b1;
                                default: fast_d = fast_q;
                            endcase
`ifdef LIGHT_CYCLE_CNT_EN
                            cyc_d   = cyc_q + 8'd1;
`endif
                        end else begin
                            light_d = ~light_q;
                            alt_d   = alt_q + ACW'(1);
                        end
                    end
                    default: phase_d = PH_GAP;
                endcase
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign light      = light_q;
    assign phase      = phase_q;
    assign speed_fast = fast_q;
    assign step_tick  = tick_q;
`ifdef LIGHT_CYCLE_CNT_EN
    assign cycle_cnt  = cyc_q;
`endif

endmodule

// File: tb/tb_light_seq_param.sv
// Bench for light_seq_param (WIDTH=8, SLOW_DIV=4, FAST_DIV=2, ALT_REPS=1) against a show-level model.
module tb_light_seq_param;

    logic       clk100khz = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] speed_mode = 2'b00;
    logic       dir = 1'b0;
    logic [7:0] light;
    logic [1:0] phase;
    logic       speed_fast;
    logic       step_tick;
`ifdef LIGHT_CYCLE_CNT_EN
    logic [7:0] cycle_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: position within the 12-tick show, latched run direction, rate, show count.
    int m_idx;
    bit m_rdir;
    bit m_fast;
    int m_cyc;

    light_seq_param #(
        .WIDTH(8),
        .SLOW_DIV(4),
        .FAST_DIV(2),
        .ALT_REPS(1)
    ) dut (
        .clk100khz(clk100khz),
        .rst_n(rst_n),
        .en(en),
        .speed_mode(speed_mode),
        .dir(dir),
        .light(light),
        .phase(phase),
        .speed_fast(speed_fast),
        .step_tick(step_tick)
`ifdef LIGHT_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 clk100khz = ~clk100khz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_light(input int idx, input bit rdir);
        logic [7:0] a;
        bit use_a;
        a = 8'hAA;
        if (idx == 0) return 8'hFF;
        if (idx <= 8) return rdir ? 8'(1 << (idx - 1)) : 8'(8'h80 >> (idx - 1));
        if (idx <= 10) begin
            use_a = (((idx - 9) % 2) == 0) ? !rdir : rdir;
            return use_a ? a : ~a;
        end
        return 8'h00;
    endfunction

    function automatic logic [1:0] model_phase(input int idx);
        if (idx == 0) return 2'd0;
        if (idx <= 8) return 2'd1;
        if (idx <= 10) return 2'd2;
        return 2'd3;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_rdir = 1'b0;
        m_fast = 1'b0;
        m_cyc  = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_light"}, 32'(light), 32'h0);
        check({tag, "_phase"}, 32'(phase), 32'd3);
        check({tag, "_fast"}, 32'(speed_fast), 32'd0);
        check({tag, "_tick"}, 32'(step_tick), 32'd0);
`ifdef LIGHT_CYCLE_CNT_EN
        check({tag, "_cyc"}, 32'(cycle_cnt), 32'd0);
`endif
    endtask

    // Waits for the next step_tick (called on a negedge), optionally freezing en for
    // 10 clocks starting pause_at negedges in, then compares against the model.
    task automatic do_tick(input int pause_at);
        logic [7:0] el;
        logic [7:0] held;
        int sp;
        int expsp;
        bit got;
        if (m_idx == 1) m_rdir = dir;
        el    = model_light(m_idx, m_rdir);
        expsp = (m_fast ? 2 : 4) + ((pause_at > 0) ? 10 : 0);
        sp  = 0;
        got = 1'b0;
        while (!got && sp < 200) begin
            @(negedge clk100khz);
            sp++;
            if (pause_at > 0 && sp == pause_at) begin
                en   = 1'b0;
                held = light;
                repeat (10) begin
                    @(negedge clk100khz);
                    sp++;
                    check("pause_tick", 32'(step_tick), 32'd0);
                    check("pause_light", 32'(light), 32'(held));
                end
                en = 1'b1;
            end
            if (step_tick) got = 1'b1;
        end
        if (!got) begin
            check("tick_timeout", 32'd0, 32'd1);
        end else begin
            check("light", 32'(light), 32'(el));
            check("phase", 32'(phase), 32'(model_phase(m_idx)));
            check("spacing", 32'(sp), 32'(expsp));
        end
        if (m_idx == 11) begin
            case (speed_mode)
                2'b00:   m_fast = !m_fast;
                2'b01:   m_fast = 1'b0;
                2'b10:   m_fast = 1'b1;
                default: m_fast = m_fast;
            endcase
            m_cyc = (m_cyc + 1) % 256;
        end
        check("speed_fast", 32'(speed_fast), 32'(m_fast));
`ifdef LIGHT_CYCLE_CNT_EN
        check("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
`endif
        m_idx = (m_idx + 1) % 12;
    endtask

    initial begin
        en = 1'b1;
        dir = 1'b0;
        speed_mode = 2'b00;
        model_reset();
        repeat (3) @(negedge clk100khz);
        check_reset("rst");
        rst_n = 1'b1;

        // Auto-alternate, MSB->LSB: slow show then fast show.
        repeat (24) do_tick(0);

        // Fixed slow, LSB->MSB, three shows.
        dir = 1'b1;
        speed_mode = 2'b01;
        repeat (36) do_tick(0);

        // Direction flipped after the 4th tick of a show must not bend the run.
        for (int t = 0; t < 12; t++) begin
            do_tick(0);
            if (t == 3) dir = ~dir;
        end

        // Randomised shows: random dir / speed_mode changes and en pauses.
        for (int s = 0; s < 5; s++) begin
            for (int t = 0; t < 12; t++) begin
                do_tick(($urandom_range(0, 7) == 0) ? 1 : 0);
                if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) speed_mode = 2'($urandom_range(0, 3));
            end
        end

        // Force slow, then request fast in the middle of ALT.
        speed_mode = 2'b01;
        repeat (12) do_tick(0);
        for (int t = 0; t < 12; t++) begin
            do_tick(0);
            if (t == 9) speed_mode = 2'b10;
        end

        // en frozen for 10 clocks mid-RUN.
        for (int t = 0; t < 12; t++) do_tick((t == 4) ? 1 : 0);

        // Asynchronous reset between edges while in ALT (speed_fast is 1 here).
        repeat (10) do_tick(0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        @(negedge clk100khz);
        rst_n = 1'b1;
        model_reset();
        speed_mode = 2'b00;
        repeat (36) do_tick(0);
`ifdef LIGHT_CYCLE_CNT_EN
        check("cyc_after3", 32'(cycle_cnt), 32'd3);
        speed_mode = 2'b10;
        repeat (256 * 12) do_tick(0);
        check("cyc_wrap", 32'(cycle_cnt), 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/light_seq_param.md
Name: light_seq_param

Overview:
- Parametrised LED pattern sequencer; next generation of the board's fixed 8-LED demo sequencer.
- Generates a repeating show: all-on, running light, alternating checkerboard, blank gap.
- Step rate is selectable between two divided rates. Mode auto-alternates or is fixed by input.
- Direction selectable; width and step rates set by parameters.
- Drives the board LED bank directly from the 100 kHz system clock.

Parameters:
WIDTH, 8, number of LEDs (>=2)
SLOW_DIV, 50000, clk100khz cycles per step in slow speed (>=2)
FAST_DIV, 5000, clk100khz cycles per step in fast speed (>=2, <SLOW_DIV)
ALT_REPS, 1, number of checkerboard pattern pairs per show (>=1)

Ports:
clk100khz  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  run enable; 0 freezes divider and display
speed_mode  input  2  00 auto alternate, 01 fixed slow, 10 fixed fast, 11 hold current
dir  input  1  0 run MSB->LSB, 1 run LSB->MSB
light  output  WIDTH  LED drive, 1 = on, registered
phase  output  2  displayed segment: 0 ALL, 1 RUN, 2 ALT, 3 GAP
speed_fast  output  1  current step rate, 1 = FAST_DIV
step_tick  output  1  one-cycle pulse when a new light value appears

Behaviour:
- Reset (async, immediate, also mid-show): light=0, phase=3 (GAP), speed_fast=0, step_tick=0, divider count=0, ALT/RUN counters=0.
- Divider: count increments each clock while en=1. Divisor is SLOW_DIV if speed_fast=0, else FAST_DIV.
- When en=1 and count==divisor-1, a tick occurs: count<=0, the display advances, and step_tick=1 for that single cycle.
- New light/phase and step_tick=1 become visible in the same cycle; there is 1 clock of register latency from the terminal count.
- en=0: count, light, phase and speed_fast hold; step_tick=0. Raising en resumes from the held count.
- Segment transitions (each on a tick):
  - GAP -> ALL: light = all ones; hold 1 tick.
  - ALL -> RUN: dir is sampled here and held for the whole run.
    - dir=0: light = one-hot MSB, then shift right each tick.
    - dir=1: light = one-hot LSB, then shift left each tick.
    - RUN lasts exactly WIDTH ticks and ends with the opposite-end bit lit.
  - RUN -> ALT: first pattern has the last-lit bit clear, then alternates each tick, for 2*ALT_REPS ticks.
    - Pattern A: bit i = 1 when (WIDTH-1-i) is even, MSB set (8-bit: AA).
    - Pattern B is ~A (55).
    - dir=0 starts with A; dir=1 starts with B.
  - ALT -> GAP: light = 0 for 1 tick.
- Show length = WIDTH + 2*ALT_REPS + 2 ticks.
- Speed update only on the tick entering GAP:
  - speed_mode 00: speed_fast <= ~speed_fast.
  - 01: speed_fast <= 0.
  - 10: speed_fast <= 1.
  - 11: speed_fast unchanged.
  - The GAP step and the following show use the new divisor.
  - speed_mode changes mid-show have no effect until the next GAP entry.
- dir changes mid-RUN are ignored until the next ALL->RUN.

Optional Feature:
- Macro LIGHT_CYCLE_CNT_EN.
- Defined: adds output cycle_cnt[7:0], reset 0. It increments on every tick entering GAP and wraps 255->0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Parameters WIDTH=8, SLOW_DIV=4, FAST_DIV=2, ALT_REPS=1; speed_mode=00, dir=0, en=1, after reset:
  - Required light sequence at successive ticks: FF,80,40,20,10,08,04,02,01,AA,55,00.
  - Tick spacing 4 clocks; speed_fast=1 from the 12th tick.
  - The next show repeats with 2-clock spacing.
- dir=1, speed_mode=01: required sequence FF,01,02,04,08,10,20,40,80,55,AA,00. speed_fast stays 0 across 3 shows.
- Toggle dir during RUN at the 4th tick -> the running direction is unchanged until the next show.
- Set speed_mode=10 mid-ALT -> speed_fast changes only at the 00 (GAP) tick.
- en=0 for 10 clocks mid-RUN -> light, count and phase frozen; no step_tick. Resume completes the remaining divider cycles.
- Assert rst_n=0 asynchronously between clock edges during ALT -> outputs are 0/phase=3 immediately, without waiting for a clock edge.
  - After release, the first tick shows FF at slow rate.
  - With LIGHT_CYCLE_CNT_EN defined, cycle_cnt=0 after the reset, 3 after three shows, and wraps after 256 shows.
